iru_rot_angle_seq: RTL

Angle sequencer for the image rotation unit (IRU). It accepts a sweep command: start angle index, step and count, in 10° units over 36 positions. It then streams one rotation coefficient set per beat to the rotation datapath: angle index, one-hot angle, sin and cos in Q2.30. Two `iru_sin_lut` instances supply the coefficients; the block owns index arithmetic, wrap-around, handshaking and sweep termination.

---
 rtl/iru_rot_angle_seq_pkg.sv | 23 ++
 rtl/iru_rot_angle_seq_if.sv | 33 +++
 rtl/iru_rot_angle_seq_add.sv | 18 +
 rtl/iru_sin_lut.sv | 34 +++
 rtl/iru_rot_angle_seq.sv | 116 +++++++++++
 5 files changed

// File: rtl/iru_rot_angle_seq_pkg.sv
// Shared types and constants for the IRU angle sequencer.
// 36 angle positions at 10 degrees each; the cos path reuses the sin table a quarter turn ahead.
package iru_pkg;

   localparam int IRU_NUM_ANGLES = 36;
   localparam int IRU_QUARTER    = 9;

   typedef logic [5:0]  iru_angle_idx_t;
   typedef logic [35:0] iru_angle_onehot_t;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_EMIT = 1'b1
   } iru_seq_state_t;

   function automatic logic iru_cfg_bad(input iru_angle_idx_t start_idx,
                                        input logic [5:0]     step,
                                        input logic [5:0]     count);
      return (start_idx >= 6'(IRU_NUM_ANGLES)) || (step == 6'd0) ||
             (step >= 6'(IRU_NUM_ANGLES)) || (count == 6'd0);
   endfunction

endpackage

// File: rtl/iru_rot_angle_seq_if.sv
// Command and coefficient-stream bundle between a sweep master and the angle sequencer.
interface iru_rot_angle_seq_if #(parameter int DATA_W = 32);
   import iru_pkg::*;

   logic              start_valid;
   logic              start_ready;
   iru_angle_idx_t    cfg_start_idx;
   logic [5:0]        cfg_step;
   logic [5:0]        cfg_count;
   logic              abort;
   logic              out_valid;
   logic              out_ready;
   iru_angle_idx_t    out_idx;
   iru_angle_onehot_t out_onehot;
   logic [DATA_W-1:0] out_sin;
   logic [DATA_W-1:0] out_cos;
   logic              out_last;
   logic              busy;
   logic              cfg_err;

   modport master (
      output start_valid, cfg_start_idx, cfg_step, cfg_count, abort, out_ready,
      input  start_ready, out_valid, out_idx, out_onehot, out_sin, out_cos,
             out_last, busy, cfg_err
   );

   modport slave (
      input  start_valid, cfg_start_idx, cfg_step, cfg_count, abort, out_ready,
      output start_ready, out_valid, out_idx, out_onehot, out_sin, out_cos,
             out_last, busy, cfg_err
   );

endinterface

// File: rtl/iru_rot_angle_seq_add.sv
// Mod-36 angle index add with one-hot encode of the result.
module iru_angle_add
   import iru_pkg::*;
(
   input  iru_angle_idx_t    base,
   input  iru_angle_idx_t    inc,
   output iru_angle_idx_t    sum,
   output iru_angle_onehot_t onehot
);

   logic [6:0] raw;

   // Both operands are below 36, so one conditional subtract is a full wrap.
   assign raw    = {1'b0, base} + {1'b0, inc};
   assign sum    = (raw >= 7'(IRU_NUM_ANGLES)) ? 6'(raw - 7'(IRU_NUM_ANGLES)) : raw[5:0];
   assign onehot = iru_angle_onehot_t'(1) << sum;

endmodule

// File: rtl/iru_sin_lut.sv
// sin(idx*10 deg) in Q2.30, magnitudes truncated toward zero from double-precision sin.
module iru_sin_lut
   import iru_pkg::*;
(
   input  iru_angle_idx_t idx,
   output logic [31:0]    sin
);

   always_comb begin
      sin = 32'h0;
      case (idx)
         6'd0:  sin = 32'h00000000;  6'd1:  sin = 32'h0B1D0D3F;
         6'd2:  sin = 32'h15E3A874;  6'd3:  sin = 32'h1FFFFFFF;
         6'd4:  sin = 32'h29236EA4;  6'd5:  sin = 32'h3106DF45;
         6'd6:  sin = 32'h376CF5D0;  6'd7:  sin = 32'h3C23EC84;
         6'd8:  sin = 32'h3F071719;  6'd9:  sin = 32'h40000000;
         6'd10: sin = 32'h3F071719;  6'd11: sin = 32'h3C23EC84;
         6'd12: sin = 32'h376CF5D0;  6'd13: sin = 32'h3106DF45;
         6'd14: sin = 32'h29236EA4;  6'd15: sin = 32'h1FFFFFFF;
         6'd16: sin = 32'h15E3A874;  6'd17: sin = 32'h0B1D0D3F;
         6'd18: sin = 32'h00000000;  6'd19: sin = 32'hF4E2F2C1;
         6'd20: sin = 32'hEA1C578C;  6'd21: sin = 32'hE0000000;
         6'd22: sin = 32'hD6DC915C;  6'd23: sin = 32'hCEF920BB;
         6'd24: sin = 32'hC8930A30;  6'd25: sin = 32'hC3DC137C;
         6'd26: sin = 32'hC0F8E8E7;  6'd27: sin = 32'hC0000000;
         6'd28: sin = 32'hC0F8E8E7;  6'd29: sin = 32'hC3DC137C;
         6'd30: sin = 32'hC8930A30;  6'd31: sin = 32'hCEF920BB;
         6'd32: sin = 32'hD6DC915C;  6'd33: sin = 32'hE0000000;
         6'd34: sin = 32'hEA1C578C;  6'd35: sin = 32'hF4E2F2C1;
         default: sin = 32'h0;
      endcase
   end

endmodule

// File: rtl/iru_rot_angle_seq.sv
// Angle sweep sequencer: turns a start/step/count command into a stream of
// registered (idx, one-hot, sin, cos) beats for the rotation datapath.
module iru_rot_angle_seq
   import iru_pkg::*;
#(
   parameter int NUM_ANGLES = 36,
   parameter int DATA_W     = 32
) (
   input logic clk,
   input logic rst,
   iru_rot_angle_seq_if.slave bus
);

   iru_seq_state_t    state, state_d;
   logic [5:0]        step_q, step_d;
   logic [5:0]        rem_q, rem_d;
   logic              vld_d, last_d, err_d, load, clr, bad;
   iru_angle_idx_t    add_base, add_inc, nxt_idx, cos_idx;
   iru_angle_onehot_t nxt_onehot, cos_onehot;
   logic [DATA_W-1:0] sin_d, cos_d;

   // In IDLE the adder passes the start index through so one LUT path serves load and advance.
   assign add_base = (state == S_IDLE) ? bus.cfg_start_idx : bus.out_idx;
   assign add_inc  = (state == S_IDLE) ? 6'd0 : step_q;
   assign bad      = iru_cfg_bad(bus.cfg_start_idx, bus.cfg_step, bus.cfg_count) ||
                     (bus.cfg_start_idx >= 6'(NUM_ANGLES));

   iru_angle_add u_nxt_add (.base(add_base), .inc(add_inc), .sum(nxt_idx), .onehot(nxt_onehot));
   iru_angle_add u_cos_add (.base(nxt_idx), .inc(6'(IRU_QUARTER)), .sum(cos_idx), .onehot(cos_onehot));
   iru_sin_lut   u_sin_lut (.idx(nxt_idx), .sin(sin_d));
   iru_sin_lut   u_cos_lut (.idx(cos_idx), .sin(cos_d));

   assign bus.start_ready = (state == S_IDLE);
   assign bus.busy        = (state != S_IDLE);

   always_comb begin
      state_d = state;
      step_d  = step_q;
      rem_d   = rem_q;
      vld_d   = bus.out_valid;
      last_d  = bus.out_last;
      err_d   = 1'b0;
      load    = 1'b0;
      clr     = 1'b0;
      case (state)
         S_IDLE: begin
            if (!bus.abort && bus.start_valid) begin
               if (bad) begin
                  err_d = 1'b1;
               end else begin
                  state_d = S_EMIT;
                  step_d  = bus.cfg_step;
                  rem_d   = bus.cfg_count;
                  vld_d   = 1'b1;
                  last_d  = (bus.cfg_count == 6'd1);
                  load    = 1'b1;
               end
            end
         end
         S_EMIT: begin
            // Abort ends the sweep even if the current beat was also accepted.
            if (bus.abort) begin
               state_d = S_IDLE;
               vld_d   = 1'b0;
               last_d  = 1'b0;
               clr     = 1'b1;
            end else if (bus.out_ready) begin
               if (rem_q == 6'd1) begin
                  state_d = S_IDLE;
                  vld_d   = 1'b0;
                  last_d  = 1'b0;
               end else begin
                  rem_d  = rem_q - 6'd1;
                  last_d = (rem_q == 6'd2);
                  load   = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         step_q         <= '0;
         rem_q          <= '0;
         bus.out_valid  <= 1'b0;
         bus.out_last   <= 1'b0;
         bus.cfg_err    <= 1'b0;
         bus.out_idx    <= '0;
         bus.out_onehot <= '0;
         bus.out_sin    <= '0;
         bus.out_cos    <= '0;
      end else begin
         state         <= state_d;
         step_q        <= step_d;
         rem_q         <= rem_d;
         bus.out_valid <= vld_d;
         bus.out_last  <= last_d;
         bus.cfg_err   <= err_d;
         if (clr) begin
            bus.out_idx    <= '0;
            bus.out_onehot <= '0;
            bus.out_sin    <= '0;
            bus.out_cos    <= '0;
         end else if (load) begin
            bus.out_idx    <= nxt_idx;
            bus.out_onehot <= nxt_onehot;
            bus.out_sin    <= sin_d;
            bus.out_cos    <= cos_d;
         end
      end
   end

endmodule
